// File: rtl/pe_cluster_iact_distributor_pkg.sv
// Shared types and constants for the PE-cluster iact distributor and the PE cluster.
// The optional per-router stall counters are enabled with IACT_DIST_STALL_CNT_EN.
package pe_cluster_pkg;

    localparam int unsigned IACT_ADDR_W = 8;
    localparam int unsigned IACT_DATA_W = 13;
    localparam int unsigned STALL_CNT_W = 32;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_DIAG  = 2'd2,
        MODE_BCAST = 2'd3
    } mode_e;

    // Router feeding PE (r,c) under the given topology.
    function automatic int unsigned src_of(mode_e mode, int unsigned r, int unsigned c,
                                           int unsigned num_in);
        case (mode)
            MODE_HORIZ: return r;
            MODE_VERT:  return c;
            MODE_DIAG:  return (r + c) % num_in;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/pe_cluster_iact_distributor_if.sv
// Router-side, PE-side and configuration signals of the iact distributor.
// slave = the distributor, master = the routers/PEs/config driving it.
interface pe_cluster_iact_distributor_if
    import pe_cluster_pkg::*;
#(
    parameter int unsigned ROWS   = 3,
    parameter int unsigned COLS   = 3,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned ADDR_W = IACT_ADDR_W,
    parameter int unsigned DATA_W = IACT_DATA_W
);
    localparam int unsigned NUM_PE = ROWS * COLS;

    logic                          cfg_valid;
    logic [1:0]                    cfg_mode;
    logic                          cfg_ready;
    logic [NUM_IN-1:0]             in_addr_valid;
    logic [NUM_IN-1:0]             in_addr_ready;
    logic [NUM_IN*ADDR_W-1:0]      in_addr_bits;
    logic [NUM_IN-1:0]             in_data_valid;
    logic [NUM_IN-1:0]             in_data_ready;
    logic [NUM_IN*DATA_W-1:0]      in_data_bits;
    logic [NUM_PE-1:0]             pe_addr_valid;
    logic [NUM_PE-1:0]             pe_addr_ready;
    logic [NUM_PE*ADDR_W-1:0]      pe_addr_bits;
    logic [NUM_PE-1:0]             pe_data_valid;
    logic [NUM_PE-1:0]             pe_data_ready;
    logic [NUM_PE*DATA_W-1:0]      pe_data_bits;
    logic [NUM_IN*STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output cfg_valid, cfg_mode, in_addr_valid, in_addr_bits, in_data_valid, in_data_bits,
               pe_addr_ready, pe_data_ready,
        input  cfg_ready, in_addr_ready, in_data_ready, pe_addr_valid, pe_addr_bits,
               pe_data_valid, pe_data_bits, stall_cnt
    );

    modport slave (
        input  cfg_valid, cfg_mode, in_addr_valid, in_addr_bits, in_data_valid, in_data_bits,
               pe_addr_ready, pe_data_ready,
        output cfg_ready, in_addr_ready, in_data_ready, pe_addr_valid, pe_addr_bits,
               pe_data_valid, pe_data_bits, stall_cnt
    );

endinterface

// File: rtl/pe_cluster_iact_distributor_fifo.sv
// Per-PE, per-stream buffer: registered count, no fall-through; output word is the head entry.
module iact_dist_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_cluster_iact_distributor.sv
// Forks each router iact stream to the PEs of a ROWS x COLS cluster under a runtime topology.
// Optional per-router stall counters: define IACT_DIST_STALL_CNT_EN.
module pe_cluster_iact_distributor
    import pe_cluster_pkg::*;
#(
    parameter int unsigned ROWS       = 3,
    parameter int unsigned COLS       = 3,
    parameter int unsigned NUM_IN     = 3,
    parameter int unsigned ADDR_W     = IACT_ADDR_W,
    parameter int unsigned DATA_W     = IACT_DATA_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    pe_cluster_iact_distributor_if.slave bus
);
    localparam int unsigned NUM_PE = ROWS * COLS;
    localparam int unsigned SRC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    mode_e             mode;
    logic [SRC_W-1:0]  src [NUM_PE];
    logic [ADDR_W-1:0] in_addr_word [NUM_IN];
    logic [DATA_W-1:0] in_data_word [NUM_IN];
    logic [NUM_IN-1:0] mapped;
    logic [NUM_IN-1:0] addr_blocked;
    logic [NUM_IN-1:0] data_blocked;
    logic [NUM_IN-1:0] addr_ready;
    logic [NUM_IN-1:0] data_ready;
    logic [NUM_PE-1:0] addr_full;
    logic [NUM_PE-1:0] data_full;
    logic [NUM_PE-1:0] addr_empty;
    logic [NUM_PE-1:0] data_empty;
    logic [NUM_PE-1:0] addr_push;
    logic [NUM_PE-1:0] data_push;
    logic              cfg_ready;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        assign in_addr_word[i] = bus.in_addr_bits[i*ADDR_W +: ADDR_W];
        assign in_data_word[i] = bus.in_data_bits[i*DATA_W +: DATA_W];
    end

    for (genvar p = 0; p < NUM_PE; p++) begin : g_src
        assign src[p] = SRC_W'(src_of(mode, p / COLS, p % COLS, NUM_IN));
    end

    // A router is blocked on a stream if any of its destination buffers is full.
    always_comb begin
        mapped       = '0;
        addr_blocked = '0;
        data_blocked = '0;
        for (int unsigned p = 0; p < NUM_PE; p++) begin
            mapped[src[p]] = 1'b1;
            if (addr_full[p]) addr_blocked[src[p]] = 1'b1;
            if (data_full[p]) data_blocked[src[p]] = 1'b1;
        end
    end

    assign addr_ready        = mapped & ~addr_blocked;
    assign data_ready        = mapped & ~data_blocked;
    assign bus.in_addr_ready = addr_ready;
    assign bus.in_data_ready = data_ready;
    assign cfg_ready         = (&addr_empty) & (&data_empty);
    assign bus.cfg_ready     = cfg_ready;

    for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
        assign addr_push[p] = bus.in_addr_valid[src[p]] & addr_ready[src[p]];
        assign data_push[p] = bus.in_data_valid[src[p]] & data_ready[src[p]];

        iact_dist_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_addr_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (addr_push[p]),
            .push_data (in_addr_word[src[p]]),
            .pop       (bus.pe_addr_ready[p]),
            .pop_data  (bus.pe_addr_bits[p*ADDR_W +: ADDR_W]),
            .full      (addr_full[p]),
            .empty     (addr_empty[p])
        );

        iact_dist_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (data_push[p]),
            .push_data (in_data_word[src[p]]),
            .pop       (bus.pe_data_ready[p]),
            .pop_data  (bus.pe_data_bits[p*DATA_W +: DATA_W]),
            .full      (data_full[p]),
            .empty     (data_empty[p])
        );

        assign bus.pe_addr_valid[p] = ~addr_empty[p];
        assign bus.pe_data_valid[p] = ~data_empty[p];
    end

    // Accepts in the cycle of a mode change still use the old map: src follows the registered mode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode <= MODE_HORIZ;
        end else if (bus.cfg_valid && cfg_ready) begin
            mode <= mode_e'(bus.cfg_mode);
        end
    end

`ifdef IACT_DIST_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q [NUM_IN];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_IN; i++) stall_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (((bus.in_addr_valid[i] & ~addr_ready[i]) |
                     (bus.in_data_valid[i] & ~data_ready[i])) && (stall_q[i] != '1)) begin
                    stall_q[i] <= stall_q[i] + STALL_CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_stall
        assign bus.stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] = stall_q[i];
    end
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_cluster_iact_distributor.sv
// Directed + randomized bench for pe_cluster_iact_distributor against a queue-based reference model.
module tb_pe_cluster_iact_distributor;
    localparam int unsigned ROWS = 3, COLS = 3, NUM_IN = 3, ADDR_W = 8, DATA_W = 13, DEPTH = 2;
    localparam int unsigned NUM_PE = ROWS * COLS;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pe_cluster_iact_distributor_if #(.ROWS(ROWS), .COLS(COLS), .NUM_IN(NUM_IN),
                                     .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pe_cluster_iact_distributor #(.ROWS(ROWS), .COLS(COLS), .NUM_IN(NUM_IN), .ADDR_W(ADDR_W),
                                  .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned       m_mode;
    logic [ADDR_W-1:0] aq [NUM_PE][$];
    logic [DATA_W-1:0] dq [NUM_PE][$];
    int unsigned       m_stall [NUM_IN];
    logic [NUM_IN-1:0] exp_ar, exp_dr;
    int unsigned       acc_a [NUM_IN];
    int unsigned       acc_d [NUM_IN];
    int unsigned       blk_cycles;

    function automatic int unsigned m_src(int unsigned mode, int unsigned p);
        int unsigned r = p / COLS;
        int unsigned c = p % COLS;
        case (mode)
            0:       return r;
            1:       return c;
            2:       return (r + c) % NUM_IN;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_empty();
        for (int unsigned p = 0; p < NUM_PE; p++)
            if (aq[p].size() != 0 || dq[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int unsigned p = 0; p < NUM_PE; p++) begin
            aq[p].delete();
            dq[p].delete();
        end
        for (int unsigned i = 0; i < NUM_IN; i++) m_stall[i] = 0;
        m_mode = 0;
    endtask

    task automatic model_ready();
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            bit used = 1'b0, a_ok = 1'b1, d_ok = 1'b1;
            for (int unsigned p = 0; p < NUM_PE; p++) begin
                if (m_src(m_mode, p) == i) begin
                    used = 1'b1;
                    if (aq[p].size() >= DEPTH) a_ok = 1'b0;
                    if (dq[p].size() >= DEPTH) d_ok = 1'b0;
                end
            end
            exp_ar[i] = used && a_ok;
            exp_dr[i] = used && d_ok;
        end
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.cfg_valid     = 1'b0;
        bus.cfg_mode      = 2'd0;
        bus.in_addr_valid = '0;
        bus.in_data_valid = '0;
        bus.in_addr_bits  = '0;
        bus.in_data_bits  = '0;
    endtask

    task automatic rand_drive(int unsigned cfg_pct);
        bus.in_addr_valid = NUM_IN'($urandom);
        bus.in_data_valid = NUM_IN'($urandom);
        bus.in_addr_bits  = (NUM_IN*ADDR_W)'($urandom);
        bus.in_data_bits  = (NUM_IN*DATA_W)'({$urandom, $urandom});
        bus.pe_addr_ready = NUM_PE'($urandom | $urandom);
        bus.pe_data_ready = NUM_PE'($urandom | $urandom);
        bus.cfg_valid     = ($urandom_range(99) < cfg_pct);
        bus.cfg_mode      = 2'($urandom);
    endtask

    // Called at a negedge with inputs driven; checks, advances one clock, returns at the next negedge.
    task automatic step();
        logic [NUM_PE-1:0]        ev_a, ev_d;
        logic [127:0]             eb_a, eb_d, mk_a, mk_d;
        logic [NUM_IN*32-1:0]     es;
        logic                     all_empty;
        logic [NUM_IN-1:0]        obs_ar, obs_dr, va, vd;
        logic [NUM_PE-1:0]        ra, rd;
        logic [NUM_IN*ADDR_W-1:0] ba;
        logic [NUM_IN*DATA_W-1:0] bd;
        logic                     cv;
        logic [1:0]               cm;
        #1;
        model_ready();
        ev_a = '0; ev_d = '0; eb_a = '0; eb_d = '0; mk_a = '0; mk_d = '0; es = '0;
        all_empty = model_empty();
        for (int unsigned p = 0; p < NUM_PE; p++) begin
            if (aq[p].size() != 0) begin
                ev_a[p] = 1'b1;
                eb_a[p*ADDR_W +: ADDR_W] = aq[p][0];
                mk_a[p*ADDR_W +: ADDR_W] = '1;
            end
            if (dq[p].size() != 0) begin
                ev_d[p] = 1'b1;
                eb_d[p*DATA_W +: DATA_W] = dq[p][0];
                mk_d[p*DATA_W +: DATA_W] = '1;
            end
        end
`ifdef IACT_DIST_STALL_CNT_EN
        for (int unsigned i = 0; i < NUM_IN; i++) es[i*32 +: 32] = 32'(m_stall[i]);
`endif
        obs_ar = bus.in_addr_ready;
        obs_dr = bus.in_data_ready;
        chk("in_addr_ready", obs_ar, exp_ar);
        chk("in_data_ready", obs_dr, exp_dr);
        chk("pe_addr_valid", bus.pe_addr_valid, ev_a);
        chk("pe_data_valid", bus.pe_data_valid, ev_d);
        chk("pe_addr_bits", 128'(bus.pe_addr_bits) & mk_a, eb_a);
        chk("pe_data_bits", 128'(bus.pe_data_bits) & mk_d, eb_d);
        chk("cfg_ready", bus.cfg_ready, all_empty);
        chk("stall_cnt", bus.stall_cnt, es);
        va = bus.in_addr_valid; vd = bus.in_data_valid;
        ba = bus.in_addr_bits;  bd = bus.in_data_bits;
        ra = bus.pe_addr_ready; rd = bus.pe_data_ready;
        cv = bus.cfg_valid;     cm = bus.cfg_mode;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (va[i] && obs_ar[i]) acc_a[i]++;
            if (vd[i] && obs_dr[i]) acc_d[i]++;
            if ((va[i] && !obs_ar[i]) || (vd[i] && !obs_dr[i])) blk_cycles++;
        end
        @(posedge clock);
        for (int unsigned p = 0; p < NUM_PE; p++) begin
            int unsigned s = m_src(m_mode, p);
            if (aq[p].size() != 0 && ra[p]) void'(aq[p].pop_front());
            if (dq[p].size() != 0 && rd[p]) void'(dq[p].pop_front());
            if (va[s] && exp_ar[s]) aq[p].push_back(ba[s*ADDR_W +: ADDR_W]);
            if (vd[s] && exp_dr[s]) dq[p].push_back(bd[s*DATA_W +: DATA_W]);
        end
        for (int unsigned i = 0; i < NUM_IN; i++)
            if (((va[i] && !exp_ar[i]) || (vd[i] && !exp_dr[i])) && m_stall[i] != 32'hFFFF_FFFF)
                m_stall[i]++;
        if (cv && all_empty) m_mode = int'(cm);
        @(negedge clock);
    endtask

    task automatic drain();
        idle();
        bus.pe_addr_ready = '1;
        bus.pe_data_ready = '1;
        for (int k = 0; k < 20 && !model_empty(); k++) step();
    endtask

    task automatic set_mode(logic [1:0] m);
        idle();
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = m;
        step();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_pe_addr_valid", bus.pe_addr_valid, '0);
        chk("rst_pe_data_valid", bus.pe_data_valid, '0);
        chk("rst_pe_addr_bits", bus.pe_addr_bits, '0);
        chk("rst_pe_data_bits", bus.pe_data_bits, '0);
        chk("rst_cfg_ready", bus.cfg_ready, 1'b1);
        chk("rst_stall_cnt", bus.stall_cnt, '0);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w, a0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin acc_a[i] = 0; acc_d[i] = 0; end
        blk_cycles = 0;
        reset = 1'b0;
        idle();
        bus.pe_addr_ready = '0;
        bus.pe_data_ready = '0;
        @(negedge clock);
        do_reset();

        // HORIZ: router1 address reaches row 1 only
        bus.in_addr_valid = 3'b010;
        bus.in_addr_bits  = 24'h005A00;
        step();
        idle();
        chk("horiz_route", bus.pe_addr_valid, 9'b000111000);
        chk("horiz_bits", bus.pe_addr_bits[47:24], 24'h5A5A5A);
        chk("horiz_no_data", bus.pe_data_valid, '0);
        step();

        for (int k = 0; k < 150; k++) begin rand_drive(0); step(); end
        drain();

        // DIAG: router2 data reaches the anti-diagonal
        set_mode(2'd2);
        bus.pe_data_ready = '0;
        bus.in_data_valid = 3'b100;
        bus.in_data_bits  = {13'h1ABC, 26'h0};
        step();
        idle();
        chk("diag_route", bus.pe_data_valid, 9'b001010100);
        chk("diag_bits", bus.pe_data_bits[4*DATA_W +: DATA_W], 13'h1ABC);
        chk("diag_no_addr", bus.pe_addr_valid, '0);
        step();

        // Random traffic with occasional mode-change requests
        for (int k = 0; k < 200; k++) begin rand_drive(8); step(); end
        drain();

        // BCAST with PE(2,2) blocked, then a pending VERT request
        set_mode(2'd3);
        bus.pe_addr_ready = 9'h0FF;
        w = 1;
        for (int k = 0; k < 4; k++) begin
            bus.in_addr_valid = 3'b001;
            bus.in_addr_bits  = 24'(w);
            a0 = acc_a[0];
            step();
            if (acc_a[0] != a0) w++;
        end
        chk("bcast_ready", bus.in_addr_ready, 3'b000);
        chk("bcast_accepts", w, 3);
        chk("bcast_pe_valid", bus.pe_addr_valid, 9'h100);
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = 2'd1;
        step();
        chk("cfg_held", bus.cfg_ready, 1'b0);
        bus.pe_addr_ready = '1;
        for (int k = 0; k < 12; k++) begin
            bus.in_addr_valid = (w <= 3) ? 3'b001 : 3'b000;
            bus.in_addr_bits  = 24'(w);
            if (m_mode == 1) bus.cfg_valid = 1'b0;
            a0 = acc_a[0];
            step();
            if (acc_a[0] != a0) w++;
        end
        idle();
        bus.pe_addr_ready = '0;
        bus.in_addr_valid = 3'b100;
        bus.in_addr_bits  = 24'hC30000;
        step();
        idle();
        chk("vert_route", bus.pe_addr_valid, 9'b100100100);
        chk("vert_bits", bus.pe_addr_bits[23:16], 8'hC3);
        drain();

        // Throughput in HORIZ with all PEs ready
        set_mode(2'd0);
        bus.pe_addr_ready = '1;
        bus.pe_data_ready = '1;
        for (int unsigned i = 0; i < NUM_IN; i++) begin acc_a[i] = 0; acc_d[i] = 0; end
        blk_cycles = 0;
        for (int k = 0; k < 100; k++) begin
            bus.in_addr_valid = '1;
            bus.in_data_valid = '1;
            bus.in_addr_bits  = (NUM_IN*ADDR_W)'($urandom);
            bus.in_data_bits  = (NUM_IN*DATA_W)'({$urandom, $urandom});
            step();
        end
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            chk("tput_addr_accepts", acc_a[i], 100);
            chk("tput_data_accepts", acc_d[i], 100);
        end
        chk("tput_stalls", blk_cycles, 0);
        drain();

        // Reset mid-operation in DIAG with words buffered
        set_mode(2'd2);
        bus.pe_addr_ready = '0;
        bus.in_addr_valid = 3'b001;
        bus.in_addr_bits  = 24'h000011;
        step();
        bus.in_addr_bits  = 24'h000022;
        step();
        idle();
        do_reset();
        bus.in_addr_valid = 3'b010;
        bus.in_addr_bits  = 24'h007700;
        step();
        idle();
        chk("post_reset_horiz", bus.pe_addr_valid, 9'b000111000);
        drain();

        // Blocked router0: 2 accepts then 10 stalled cycles
        do_reset();
        bus.pe_addr_ready = '0;
        bus.in_addr_valid = 3'b001;
        for (int k = 0; k < 12; k++) step();
`ifdef IACT_DIST_STALL_CNT_EN
        chk("stall_10", bus.stall_cnt[31:0], 32'd10);
`else
        chk("stall_tied", bus.stall_cnt, '0);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
